// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush controller for the 5-stage MIPS core.
// Merges the ID load-use stall, sequences the multi-cycle EX divider and
// turns MEM exception redirects into an IF/ID/EX flush plus new PC.
// Optional build macro: STALL_PERF_EN adds load/divide stall perf counters;
// without it both counter ports read zero and no counter flops exist.
module pipe_stall_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_load_stall,
  input  logic        ex_div_req,
  input  logic        div_ready,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_timeout,
  output logic [31:0] load_stall_cnt,
  output logic [31:0] div_stall_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StDivStart,
    StDivBusy,
    StDivDone
  } state_e;

  localparam logic [5:0]       StallLoad = 6'b000111;
  localparam logic [5:0]       StallDiv  = 6'b001111;
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(DIV_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        start_c;
  logic        annul_c;
  logic        timeout_fire;

  // Next-state and output decode; an exception overrides everything.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    stall_c      = 6'b000000;
    flush_c      = 1'b0;
    new_pc_c     = 32'b0;
    start_c      = 1'b0;
    annul_c      = 1'b0;
    timeout_fire = 1'b0;

    if (excp_req) begin
      flush_c  = 1'b1;
      new_pc_c = excp_pc;
      annul_c  = (state_q == StDivStart) || (state_q == StDivBusy);
      state_d  = StIdle;
      cnt_d    = '0;
    end else begin
      if ((state_q == StDivStart) || (state_q == StDivBusy) ||
          ((state_q == StIdle) && ex_div_req)) begin
        stall_c = StallDiv;
      end else if (id_load_stall) begin
        stall_c = StallLoad;
      end

      unique case (state_q)
        StIdle: begin
          if (ex_div_req) state_d = StDivStart;
        end
        StDivStart: begin
          start_c = 1'b1;
          cnt_d   = '0;
          state_d = StDivBusy;
        end
        StDivBusy: begin
          if (div_ready) begin
            state_d = StDivDone;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            annul_c      = 1'b1;
            timeout_fire = 1'b1;
            timeout_d    = 1'b1;
            state_d      = StIdle;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // EX advances this cycle; a still-high ex_div_req is the old divide.
        StDivDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Controller state, busy counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs are forced low while reset is held, combinational ones included.
  assign stall       = rst ? stall_c  : 6'b000000;
  assign flush       = rst ? flush_c  : 1'b0;
  assign new_pc      = rst ? new_pc_c : 32'b0;
  assign div_start   = rst ? start_c  : 1'b0;
  assign div_annul   = rst ? annul_c  : 1'b0;
  // Timeout shows in the same cycle as the abort, then stays set.
  assign div_timeout = rst ? (timeout_q | timeout_fire) : 1'b0;

`ifdef STALL_PERF_EN
  logic [31:0] load_cnt_q;
  logic [31:0] div_cnt_q;

  // Perf counters, frozen during a flush cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_cnt_q <= 32'b0;
      div_cnt_q  <= 32'b0;
    end else if (!flush_c) begin
      if (stall_c == StallLoad) load_cnt_q <= load_cnt_q + 32'd1;
      if (stall_c == StallDiv)  div_cnt_q  <= div_cnt_q + 32'd1;
    end
  end

  assign load_stall_cnt = rst ? load_cnt_q : 32'b0;
  assign div_stall_cnt  = rst ? div_cnt_q  : 32'b0;
`else
  assign load_stall_cnt = 32'b0;
  assign div_stall_cnt  = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;

`ifdef STALL_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        id_load_stall;
  logic        ex_div_req;
  logic        div_ready;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_start;
  logic        div_annul;
  logic        div_timeout;
  logic [31:0] load_stall_cnt;
  logic [31:0] div_stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl #(
    .DIV_TIMEOUT(40),
    .CNT_W      (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_load_stall (id_load_stall),
    .ex_div_req    (ex_div_req),
    .div_ready     (div_ready),
    .excp_req      (excp_req),
    .excp_pc       (excp_pc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .div_start     (div_start),
    .div_annul     (div_annul),
    .div_timeout   (div_timeout),
    .load_stall_cnt(load_stall_cnt),
    .div_stall_cnt (div_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, settle, then check.
  task automatic cycle(input logic l, input logic d, input logic r, input logic e,
                       input logic [31:0] pc);
    @(negedge clk);
    id_load_stall = l;
    ex_div_req    = d;
    div_ready     = r;
    excp_req      = e;
    excp_pc       = pc;
    #1;
  endtask

  initial begin
    // Reset held with every input high.
    rst = 1'b0;
    id_load_stall = 1'b1;
    ex_div_req = 1'b1;
    div_ready = 1'b1;
    excp_req = 1'b1;
    excp_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_new_pc", new_pc, 32'h0);
      chk("rst_div_start", 32'(div_start), 32'h0);
      chk("rst_div_annul", 32'(div_annul), 32'h0);
      chk("rst_div_timeout", 32'(div_timeout), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    id_load_stall = 1'b0;
    ex_div_req = 1'b0;
    div_ready = 1'b0;
    excp_req = 1'b0;
    excp_pc = 32'h0;
    #1;
    chk("idle_stall", 32'(stall), 32'h0);
    chk("idle_div_start", 32'(div_start), 32'h0);
    chk("idle_load_cnt", load_stall_cnt, 32'h0);

    // Load-use: single cycle pass-through.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("load_stall", 32'(stall), 32'h07);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("load_release", 32'(stall), 32'h0);
    chk("load_cnt", load_stall_cnt, Perf ? 32'd1 : 32'd0);

    // Divide: request at T, div_ready at T+34.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("div_T_stall", 32'(stall), 32'h0F);
    chk("div_T_start", 32'(div_start), 32'h0);
    for (int k = 1; k <= 34; k++) begin
      cycle(1'b0, 1'b1, (k == 34), 1'b0, 32'h0);
      chk("div_busy_stall", 32'(stall), 32'h0F);
      chk("div_busy_start", 32'(div_start), (k == 1) ? 32'h1 : 32'h0);
      chk("div_busy_annul", 32'(div_annul), 32'h0);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("div_done_stall", 32'(stall), 32'h0);
    chk("div_done_start", 32'(div_start), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("div_after_stall", 32'(stall), 32'h0);
    chk("div_after_start", 32'(div_start), 32'h0);
    chk("div_cnt_35", div_stall_cnt, Perf ? 32'd35 : 32'd0);

    // Exception during the divide at T+10.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("fl_busy_stall", 32'(stall), 32'h0F);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC0_0380);
    chk("fl_flush", 32'(flush), 32'h1);
    chk("fl_new_pc", new_pc, 32'hBFC0_0380);
    chk("fl_annul", 32'(div_annul), 32'h1);
    chk("fl_stall", 32'(stall), 32'h0);
    chk("fl_start", 32'(div_start), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_idle_stall", 32'(stall), 32'h0);
    chk("fl_idle_flush", 32'(flush), 32'h0);
    chk("fl_idle_new_pc", new_pc, 32'h0);
    chk("fl_idle_annul", 32'(div_annul), 32'h0);
    chk("fl_div_cnt", div_stall_cnt, Perf ? 32'd45 : 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_idle2_start", 32'(div_start), 32'h0);

    // Timeout: 40th busy cycle is T+41, relaunch at T+43.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("to_busy_stall", 32'(stall), 32'h0F);
      chk("to_busy_start", 32'(div_start), (k == 1) ? 32'h1 : 32'h0);
      chk("to_busy_annul", 32'(div_annul), 32'h0);
      chk("to_busy_flag", 32'(div_timeout), 32'h0);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("to_annul", 32'(div_annul), 32'h1);
    chk("to_flag", 32'(div_timeout), 32'h1);
    chk("to_start", 32'(div_start), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("to_idle_stall", 32'(stall), 32'h0F);
    chk("to_idle_start", 32'(div_start), 32'h0);
    chk("to_idle_annul", 32'(div_annul), 32'h0);
    chk("to_sticky", 32'(div_timeout), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("to_restart", 32'(div_start), 32'h1);
    chk("to_restart_annul", 32'(div_annul), 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("to_ready_stall", 32'(stall), 32'h0F);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("to_done_stall", 32'(stall), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("to_end_stall", 32'(stall), 32'h0);
    chk("to_end_flag", 32'(div_timeout), 32'h1);
    chk("to_div_cnt", div_stall_cnt, Perf ? 32'd90 : 32'd0);

    // Priority: exception beats divide request and load stall.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0180);
    chk("pri_flush", 32'(flush), 32'h1);
    chk("pri_stall", 32'(stall), 32'h0);
    chk("pri_new_pc", new_pc, 32'h8000_0180);
    chk("pri_annul", 32'(div_annul), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pri_next_start", 32'(div_start), 32'h0);
    chk("pri_next_stall", 32'(stall), 32'h0);
    chk("pri_next_flush", 32'(flush), 32'h0);
    chk("pri_load_cnt", load_stall_cnt, Perf ? 32'd1 : 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pri_next2_start", 32'(div_start), 32'h0);

    // Reset clears the sticky timeout and counters.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_flag_low", 32'(div_timeout), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_flag", 32'(div_timeout), 32'h0);
    chk("rst2_div_cnt", div_stall_cnt, 32'h0);
    chk("rst2_load_cnt", load_stall_cnt, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Merges the ID load-use stall request, sequences the multi-cycle divider in EX, and handles MEM exception flushes.
- Drives the shared stall bus to PC/IF/ID/EX/MEM/WB and the flush/new-PC pair to IF.
- Owns the divider handshake: start pulse, busy tracking, annul on flush or timeout.

Parameters:
- DIV_TIMEOUT, 40: max cycles in DIV_BUSY without div_ready before abort.
- CNT_W, 6: width of the busy-cycle counter; must hold DIV_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
- id_load_stall  in  1  ID load-use hazard request (ID stall_for_load)
- ex_div_req  in  1  EX holds a div/divu with valid operands
- div_ready  in  1  divider result valid, one-cycle pulse
- excp_req  in  1  MEM raises an exception/eret redirect
- excp_pc  in  32  redirect target
- stall  out  6  stall bus; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop
- flush  out  1  squash IF/ID/EX registers
- new_pc  out  32  redirect PC, valid when flush=1
- div_start  out  1  one-cycle divider launch pulse
- div_annul  out  1  one-cycle divider abort pulse
- div_timeout  out  1  sticky: a divide timed out since reset
- load_stall_cnt  out  32  perf counter (optional feature)
- div_stall_cnt  out  32  perf counter (optional feature)

Behaviour:
- States: IDLE, DIV_START, DIV_BUSY, DIV_DONE. Reset state is IDLE, busy counter 0, div_timeout 0.
- While rst==0, all outputs read 0, combinational outputs included.
- Output decode is combinational from state and inputs, with priority top-down:
  1. excp_req=1: flush=1, new_pc=excp_pc, stall=6'b000000. div_annul=1 if state is DIV_START or DIV_BUSY. Next state IDLE and counter cleared, regardless of other inputs.
  2. State DIV_START or DIV_BUSY, or (IDLE and ex_div_req): stall=6'b001111.
  3. id_load_stall=1 (any state except DIV_DONE already covered): stall=6'b000111.
  4. Otherwise stall=0.
- Outside case 1: flush=0 and new_pc=32'b0.
- Transitions, without excp_req:
  - IDLE: ex_div_req=1 → DIV_START.
  - DIV_START: div_start=1 this cycle only → DIV_BUSY, counter=0.
  - DIV_BUSY: div_ready=1 → DIV_DONE. Otherwise counter+1. If counter reaches DIV_TIMEOUT-1, then div_annul=1, div_timeout←1, → IDLE.
  - DIV_DONE: stall from div released, so EX advances and captures the result. ex_div_req is ignored this cycle, preventing a restart on the same instruction. → IDLE unconditionally.
- div_ready outside DIV_BUSY is ignored.
- Divide latency seen by the pipeline: EX stalled from the request cycle through the div_ready cycle; released the cycle after div_ready.
- Load-use stall has no state; it is a pure pass-through of id_load_stall per cycle.
- After a timeout, a still-asserted ex_div_req relaunches the divide: IDLE → DIV_START next cycle.
- div_start and div_annul are never high in the same cycle.
- div_timeout clears only on reset.

Optional Feature:
- Macro STALL_PERF_EN.
- Defined:
  - load_stall_cnt increments each cycle stall==6'b000111.
  - div_stall_cnt increments each cycle stall==6'b001111.
  - Both 32-bit, wrap at 2^32-1 → 0, reset to 0, frozen in cycles where flush=1.
- Undefined: both ports tied to 32'b0 and no counter flops are built.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all inputs driven 1 → stall=0, flush=0, div_start=0, div_timeout=0; state IDLE after release.
- Load-use: id_load_stall=1 for 1 cycle → stall=6'b000111 that cycle only; with STALL_PERF_EN, load_stall_cnt=1.
- Divide: ex_div_req=1 at cycle T, div_ready at T+34 → stall=6'b001111 T..T+34; div_start=1 only at T+1; stall=0 at T+35 despite ex_div_req=1; no second div_start.
- Flush mid-divide: excp_req=1, excp_pc=32'hBFC00380 at T+10 of a divide → flush=1, new_pc=32'hBFC00380, div_annul=1, stall=0 at T+10; state IDLE at T+11.
- Timeout: DIV_TIMEOUT=40, div_ready never asserted → div_annul=1 and div_timeout=1 on the 40th DIV_BUSY cycle; div_start re-pulses 2 cycles later while ex_div_req=1.
- Priority: id_load_stall=1, ex_div_req=1, excp_req=1 in one IDLE cycle → flush=1, stall=0, div_start=0 next cycle.
